// File: rtl/truth_table_capture.sv
// Clocked truth-table reader: sweeps x_out over every input vector, samples z_in after a settle
// delay and scores the observed table against EXP_TABLE. Optional macro: TT_CAPTURE_HALT_ON_ERR_EN.
module truth_table_capture #(
  parameter int                  N_IN      = 3,
  parameter int                  SETTLE    = 2,
  parameter logic [2**N_IN-1:0]  EXP_TABLE = 8'b01000011
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                z_in,
  output logic [N_IN-1:0]     x_out,
  output logic                busy,
  output logic                done,
  output logic [2**N_IN-1:0]  captured,
  output logic [N_IN:0]       err_count,
  output logic [N_IN-1:0]     first_err_idx,
  output logic                error
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [N_IN-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE} state_t;

  state_t               state_q, state_d;
  logic [N_IN-1:0]      idx_q, idx_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [N_IN-1:0]      x_q, x_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2**N_IN-1:0]   captured_q, captured_d;
  logic [N_IN:0]        err_q, err_d;
  logic [N_IN-1:0]      first_q, first_d;
  logic                 error_q, error_d;
  logic                 mismatch;
  logic                 halt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      x_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      captured_q <= '0;
      err_q      <= '0;
      first_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      captured_q <= captured_d;
      err_q      <= err_d;
      first_q    <= first_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    captured_d = captured_q;
    err_d      = err_q;
    first_d    = first_q;
    error_d    = error_q;
    mismatch   = (z_in != EXP_TABLE[idx_q]);
`ifdef TT_CAPTURE_HALT_ON_ERR_EN
    halt       = mismatch;
`else
    halt       = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_DRIVE;
          idx_d      = '0;
          busy_d     = 1'b1;
          captured_d = '0;
          err_d      = '0;
          first_d    = '0;
          error_d    = 1'b0;
        end
      end
      S_DRIVE: begin
        x_d     = idx_q;
        cnt_d   = '0;
        state_d = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (int'(cnt_q) >= SETTLE - 1) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        captured_d[idx_q] = z_in;
        // first_err_idx latches only while the running count is still zero
        if (mismatch) begin
          err_d   = err_q + 1'b1;
          error_d = 1'b1;
          if (err_q == '0) first_d = idx_q;
        end
        if (idx_q == LAST_IDX || halt) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign x_out         = x_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign captured      = captured_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;
  assign error         = error_q;

endmodule

// File: tb/tb_truth_table_capture.sv
// Directed self-checking bench for truth_table_capture with its default parameters.
// Halt-on-error expectations apply when TT_CAPTURE_HALT_ON_ERR_EN is defined.
module tb_truth_table_capture;

  localparam int SWEEP = 32;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       z_in;
  logic [2:0] x_out;
  logic       busy, done, error;
  logic [7:0] captured;
  logic [3:0] err_count;
  logic [2:0] first_err_idx;

  int checks = 0;
  int errors = 0;
  int zMode = 0;

  truth_table_capture dut (
    .clock(clock), .reset_n(reset_n), .start(start), .z_in(z_in),
    .x_out(x_out), .busy(busy), .done(done), .captured(captured),
    .err_count(err_count), .first_err_idx(first_err_idx), .error(error)
  );

  always #5 clock = ~clock;

  // Function under test: 0 = correct f (table 0x43), 1 = stuck at 0, 2 = wrong at x=6
  always_comb begin
    logic [7:0] tbl;
    tbl = 8'h43;
    case (zMode)
      1:       z_in = 1'b0;
      2:       z_in = (x_out == 3'd6) ? ~tbl[x_out] : tbl[x_out];
      default: z_in = tbl[x_out];
    endcase
  end

  // Starts a sweep at the next edge and returns the edge offset of the first done seen
  task automatic runSweep(output int doneAt);
    doneAt = -1;
    @(negedge clock); start = 1'b1;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (done) begin doneAt = n; break; end
      @(negedge clock);
    end
  endtask

  task automatic checkResult(input string name, input int doneAt, input int expDone,
                             input logic [7:0] expCap, input logic [3:0] expErr,
                             input logic [2:0] expFirst);
    checks++;
    if (doneAt !== expDone) begin errors++; $display("[TB] FAIL %s done_edge got %0d exp %0d", name, doneAt, expDone); end
    checks++;
    if (captured !== expCap) begin errors++; $display("[TB] FAIL %s captured got %h exp %h", name, captured, expCap); end
    checks++;
    if (err_count !== expErr) begin errors++; $display("[TB] FAIL %s err_count got %0d exp %0d", name, err_count, expErr); end
    checks++;
    if (error !== (expErr != 0)) begin errors++; $display("[TB] FAIL %s error got %b exp %b", name, error, expErr != 0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL %s busy_at_done got %b exp 0", name, busy); end
    if (expErr != 0) begin
      checks++;
      if (first_err_idx !== expFirst) begin errors++; $display("[TB] FAIL %s first_err_idx got %0d exp %0d", name, first_err_idx, expFirst); end
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL %s done_width got %b exp 0", name, done); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({x_out, busy, done, captured, err_count, first_err_idx, error} !== '0) begin
      errors++;
      $display("[TB] FAIL reset outputs got %h exp 0", {x_out, busy, done, captured, err_count, first_err_idx, error});
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_correct();
    int d;
    zMode = 0;
    runSweep(d);
    checkResult("correct", d, SWEEP, 8'h43, 4'd0, 3'd0);
  endtask

  task automatic test_stuck0();
    int d;
    zMode = 1;
    runSweep(d);
`ifdef TT_CAPTURE_HALT_ON_ERR_EN
    checkResult("stuck0", d, 4, 8'h00, 4'd1, 3'd0);
`else
    checkResult("stuck0", d, SWEEP, 8'h00, 4'd3, 3'd0);
`endif
  endtask

  task automatic test_flip6();
    int d;
    zMode = 2;
    runSweep(d);
`ifdef TT_CAPTURE_HALT_ON_ERR_EN
    checkResult("flip6", d, 28, 8'h03, 4'd1, 3'd6);
`else
    checkResult("flip6", d, SWEEP, 8'h03, 4'd1, 3'd6);
`endif
  endtask

  task automatic test_back_to_back();
    int n, doneCnt, lastDone, d;
    zMode = 0;
    // busy start pulse at edge 10 must not restart the sweep
    @(negedge clock); start = 1'b1;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
    d = -1;
    for (n = 0; n < 200; n++) begin
      if (n == 9) start = 1'b1;
      if (n == 10) start = 1'b0;
      if (done) begin d = n; break; end
      @(negedge clock);
    end
    checkResult("restart_ignored", d, SWEEP, 8'h43, 4'd0, 3'd0);
    // start held high: sweeps run back to back, one done each 33 edges
    start = 1'b1;
    doneCnt = 0;
    lastDone = -1;
    for (n = 0; n < 140; n++) begin
      @(negedge clock);
      if (done) begin
        doneCnt++;
        if (lastDone >= 0) begin
          checks++;
          if (n - lastDone !== SWEEP + 1) begin errors++; $display("[TB] FAIL held_period got %0d exp %0d", n - lastDone, SWEEP + 1); end
        end
        lastDone = n;
        checks++;
        if (captured !== 8'h43 || err_count !== 4'd0) begin
          errors++; $display("[TB] FAIL held_result got %h/%0d exp 43/0", captured, err_count);
        end
      end
    end
    checks++;
    if (doneCnt !== 4) begin errors++; $display("[TB] FAIL held_done_count got %0d exp 4", doneCnt); end
    start = 1'b0;
    for (n = 0; n < 80 && busy; n++) @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_midreset();
    int n, d;
    logic sawDone;
    zMode = 0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (n = 0; n < 100 && x_out != 3'd4; n++) @(negedge clock);
    checks++;
    if (x_out !== 3'd4) begin errors++; $display("[TB] FAIL midreset_reach got %0d exp 4", x_out); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({x_out, busy, done, captured, err_count, first_err_idx, error} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_async got %h exp 0", {x_out, busy, done, captured, err_count, first_err_idx, error});
    end
    sawDone = 1'b0;
    for (n = 0; n < 3; n++) begin @(negedge clock); sawDone |= done; end
    reset_n = 1'b1;
    for (n = 0; n < 5; n++) begin @(negedge clock); sawDone |= done; end
    checks++;
    if (sawDone !== 1'b0) begin errors++; $display("[TB] FAIL midreset_no_done got %b exp 0", sawDone); end
    runSweep(d);
    checkResult("after_reset", d, SWEEP, 8'h43, 4'd0, 3'd0);
  endtask

  initial begin
    test_reset();
    test_correct();
    test_stuck0();
    test_flip6();
    test_back_to_back();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
